// File: rtl/rotate_right_seq.sv
// Iterative right rotator with valid/ready handshakes, one bit per clock.
// Define ROT_STEP2_EN to rotate two positions per clock while cnt >= 2.
module rotate_right_seq #(
  parameter int WIDTH = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nx;
  logic [WIDTH-1:0] out_nx;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   cnt_nx;

  function automatic logic [WIDTH-1:0] rot1(
    input logic [WIDTH-1:0] d
  );
    return {d[0], d[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_r   <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nx;
      data_r   <= data_nx;
      cnt      <= cnt_nx;
      out_data <= out_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = data_r;
    cnt_nx   = cnt;
    out_nx   = out_data;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_nx = in_data;
          cnt_nx  = in_amt;
          if (in_amt != '0) begin
            state_nx = SHIFT;
          end else begin
            state_nx = DONE;
            out_nx   = in_data;
          end
        end
      end
      SHIFT: begin
`ifdef ROT_STEP2_EN
        if (int'(cnt) >= 2) begin
          data_nx = rot1(rot1(data_r));
          cnt_nx  = cnt - SHW'(2);
        end else begin
          data_nx = rot1(data_r);
          cnt_nx  = cnt - SHW'(1);
        end
`else
        data_nx = rot1(data_r);
        cnt_nx  = cnt - SHW'(1);
`endif
        // result is captured on the same edge that enters DONE
        if (cnt_nx == '0) begin
          state_nx = DONE;
          out_nx   = data_nx;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
